// File: rtl/multi_clock_divider.sv
// multi_clock_divider: free-running cycle counter plus NUM_CH programmable
// tick/square channels, each retunable at run time through a one-slot
// valid/ready config port.
//
// Optional feature macro: CLKDIV_SYNC_EN (adds sync_restart_i)
//
// Ports
//   clock_i         system clock, all logic on its rising edge
//   reset_i         synchronous active-high reset
//   sync_restart_i  (CLKDIV_SYNC_EN only) realign all channel phases to 0
//   free_count_o    free-running cycle count
//   cfg_valid_i     config write request
//   cfg_ch_i        target channel index
//   cfg_div_i       new divisor D (0 halts the channel)
//   cfg_ready_o     config slot free
//   ch_enable_i     per-channel run enable
//   tick_o          one-cycle pulse per channel period
//   square_o        50% duty square wave, period 2*D
module multi_clock_divider #(
    parameter  int unsigned NUM_CH = 4,
    parameter  int unsigned CNT_W  = 32,
    parameter  int unsigned DIV_W  = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_restart_i,
`endif
    output logic [CNT_W-1:0]  free_count_o,
    input  logic              cfg_valid_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic              cfg_ready_o,
    input  logic [NUM_CH-1:0] ch_enable_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] square_o
);

    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] square_q, square_d;
    logic              pend_q, pend_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0]  pend_div_q, pend_div_d;
    logic [NUM_CH-1:0] pend_hit;
    logic              cfg_ch_ok;
    logic              restart;

`ifdef CLKDIV_SYNC_EN
    assign restart = sync_restart_i;
`else
    assign restart = 1'b0;
`endif

    // Widen by one bit so the range check is meaningful for any NUM_CH.
    assign cfg_ch_ok = ({1'b0, cfg_ch_i} < (CH_W + 1)'(NUM_CH));

    // Which channel, if any, the pending write targets.
    always_comb begin
        pend_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pend_hit[c] = pend_q && (pend_ch_q == CH_W'(c));
        end
    end

    // Next-state logic for counter, channels and config slot.
    always_comb begin
        free_count_d = free_count_q + CNT_W'(1);
        div_d        = div_q;
        cnt_d        = cnt_q;
        tick_d       = '0;
        square_d     = square_q;
        pend_d       = pend_q;
        pend_ch_d    = pend_ch_q;
        pend_div_d   = pend_div_q;

        for (int c = 0; c < NUM_CH; c++) begin
            if ((div_q[c] == '0) || !ch_enable_i[c]) begin
                // Halted or paused: a pending retune lands right away.
                if (pend_hit[c]) begin
                    div_d[c] = pend_div_q;
                    cnt_d[c] = '0;
                    pend_d   = 1'b0;
                end
            end else if (cnt_q[c] == (div_q[c] - DIV_W'(1))) begin
                // Terminal count: emit this period's tick, then retune if asked.
                cnt_d[c]    = '0;
                tick_d[c]   = 1'b1;
                square_d[c] = ~square_q[c];
                if (pend_hit[c]) begin
                    div_d[c] = pend_div_q;
                    pend_d   = 1'b0;
                end
            end else begin
                cnt_d[c] = cnt_q[c] + DIV_W'(1);
            end
        end

        // Phase realignment overrides normal channel stepping.
        if (restart) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_d[c]    = '0;
                tick_d[c]   = 1'b0;
                square_d[c] = 1'b0;
                if (pend_hit[c]) begin
                    div_d[c] = pend_div_q;
                    pend_d   = 1'b0;
                end
            end
        end

        // Accept only into an empty slot, so it never collides with a clear.
        if (cfg_valid_i && !pend_q && cfg_ch_ok) begin
            pend_d     = 1'b1;
            pend_ch_d  = cfg_ch_i;
            pend_div_d = cfg_div_i;
        end
    end

    // State registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            free_count_q <= '0;
            div_q        <= '{default: '0};
            cnt_q        <= '{default: '0};
            tick_q       <= '0;
            square_q     <= '0;
            pend_q       <= 1'b0;
            pend_ch_q    <= '0;
            pend_div_q   <= '0;
        end else begin
            free_count_q <= free_count_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            square_q     <= square_d;
            pend_q       <= pend_d;
            pend_ch_q    <= pend_ch_d;
            pend_div_q   <= pend_div_d;
        end
    end

    assign free_count_o = free_count_q;
    assign cfg_ready_o  = ~pend_q;
    assign tick_o       = tick_q;
    assign square_o     = square_q;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (NUM_CH=3 so an out-of-range
// channel index fits the 2-bit cfg_ch port; CNT_W=4 so wrap is reachable).
module tb_multi_clock_divider;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [CNT_W-1:0]  free_count;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
`ifdef CLKDIV_SYNC_EN
    logic              sync_restart;
`endif

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    multi_clock_divider #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)
    ) dut (
        .clock_i        (clk),
        .reset_i        (reset),
`ifdef CLKDIV_SYNC_EN
        .sync_restart_i (sync_restart),
`endif
        .free_count_o   (free_count),
        .cfg_valid_i    (cfg_valid),
        .cfg_ch_i       (cfg_ch),
        .cfg_div_i      (cfg_div),
        .cfg_ready_o    (cfg_ready),
        .ch_enable_i    (ch_enable),
        .tick_o         (tick),
        .square_o       (square)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle; cycles models free_count.
    task automatic step();
        @(posedge clk);
        if (reset) cycles = 0;
        else       cycles = cycles + 1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        ch_enable = '0;
`ifdef CLKDIV_SYNC_EN
        sync_restart = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;

        // Reset state after 10 free-running cycles
        repeat (10) step();
        check("rst_free_count", 32'(free_count), 32'd10);
        check("rst_tick",       32'(tick),       32'd0);
        check("rst_square",     32'(square),     32'd0);
        check("rst_ready",      32'(cfg_ready),  32'd1);

        // ch0 D=4
        ch_enable = 3'b001;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
        step();
        cfg_valid = 1'b0;
        check("d4_accept_ready", 32'(cfg_ready), 32'd0);
        step();
        check("d4_apply_ready", 32'(cfg_ready), 32'd1);
        check("d4_apply_tick",  32'(tick),      32'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("d4_tick0",   32'(tick[0]),   32'((i % 4) == 0));
            check("d4_square0", 32'(square[0]), 32'((i / 4) % 2));
            check("d4_others",  32'(tick[2:1] | square[2:1]), 32'd0);
        end

        // Retune ch0 to D=2 one cycle after its tick
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd2;
        step();
        cfg_valid = 1'b0;
        check("rt_ready_13", 32'(cfg_ready), 32'd0);
        check("rt_tick_13",  32'(tick[0]),   32'd0);
        step();
        check("rt_ready_14", 32'(cfg_ready), 32'd0);
        check("rt_tick_14",  32'(tick[0]),   32'd0);
        step();
        check("rt_ready_15", 32'(cfg_ready), 32'd0);
        check("rt_tick_15",  32'(tick[0]),   32'd0);
        step();
        check("rt_ready_16",  32'(cfg_ready), 32'd1);
        check("rt_tick_16",   32'(tick[0]),   32'd1);
        check("rt_square_16", 32'(square[0]), 32'd0);
        step();
        check("rt_tick_17",   32'(tick[0]),   32'd0);
        step();
        check("rt_tick_18",   32'(tick[0]),   32'd1);
        check("rt_square_18", 32'(square[0]), 32'd1);
        step();
        check("rt_tick_19",   32'(tick[0]),   32'd0);
        step();
        check("rt_tick_20",   32'(tick[0]),   32'd1);
        check("rt_square_20", 32'(square[0]), 32'd0);

        // Out-of-range channel index is dropped
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
        step();
        cfg_valid = 1'b0;
        check("drop_ready",  32'(cfg_ready), 32'd1);
        check("drop_tick0",  32'(tick[0]),   32'd0);
        check("drop_ch12",   32'(tick[2:1] | square[2:1]), 32'd0);
        step();
        check("drop_tick0b",   32'(tick[0]),   32'd1);
        check("drop_square0b", 32'(square[0]), 32'd1);
        check("mid_free_count", 32'(free_count), 32'(4'(cycles)));

        // ch1 D=5 with a 3-cycle enable gap mid-count
        ch_enable = 3'b011;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
        step();
        cfg_valid = 1'b0;
        check("en_accept_ready", 32'(cfg_ready), 32'd0);
        step();
        check("en_apply_ready", 32'(cfg_ready), 32'd1);
        check("en_apply_tick1", 32'(tick[1]),   32'd0);
        for (int j = 2; j <= 5; j++) begin
            step();
            check("en_tick1_pre", 32'(tick[1]), 32'd0);
        end
        step();
        check("en_tick1_6",   32'(tick[1]),   32'd1);
        check("en_square1_6", 32'(square[1]), 32'd1);
        step();
        step();
        ch_enable = 3'b001;
        for (int j = 9; j <= 11; j++) begin
            step();
            check("en_gap_tick1",   32'(tick[1]),   32'd0);
            check("en_gap_square1", 32'(square[1]), 32'd1);
        end
        ch_enable = 3'b011;
        for (int j = 12; j <= 13; j++) begin
            step();
            check("en_resume_tick1", 32'(tick[1]), 32'd0);
        end
        step();
        check("en_tick1_14",   32'(tick[1]),   32'd1);
        check("en_square1_14", 32'(square[1]), 32'd0);

        // free_count wrap
        for (int k = 0; k < 20; k++) begin
            if ((cycles % 16) == 15) break;
            step();
        end
        check("wrap_top",  32'(free_count), 32'd15);
        step();
        check("wrap_zero", 32'(free_count), 32'd0);

`ifdef CLKDIV_SYNC_EN
        // Phase realignment: ch0 D=2, ch1 D=5 both enabled
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check("sync_square", 32'(square), 32'd0);
        check("sync_tick",   32'(tick),   32'd0);
        step();
        check("sync_s1", 32'(tick), 32'b000);
        step();
        check("sync_s2", 32'(tick), 32'b001);
        step();
        step();
        check("sync_s4", 32'(tick), 32'b001);
        step();
        check("sync_s5", 32'(tick), 32'b010);
`endif

        // Reset mid-operation discards a pending write
        ch_enable = 3'b111;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd3;
        step();
        cfg_valid = 1'b0;
        check("mrst_pending", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_ready",      32'(cfg_ready),  32'd1);
        check("mrst_tick",       32'(tick),       32'd0);
        check("mrst_square",     32'(square),     32'd0);
        check("mrst_free_count", 32'(free_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("mrst_halted_tick",   32'(tick),      32'd0);
            check("mrst_halted_square", 32'(square),    32'd0);
            check("mrst_halted_ready",  32'(cfg_ready), 32'd1);
        end
        check("mrst_free_count_5", 32'(free_count), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
